// File: rtl/fu_isa_pkg.sv
// rtl/fu_isa_pkg.sv - opcode constants and instruction-class helpers for the FU issue stage
// Purpose: shared data width, FU opcodes and the compare/select classifiers.
// Ports: none (package).
package fu_isa_pkg;

    localparam int DATA_W = 32;
    localparam int OP_W   = 6;

    localparam logic [OP_W-1:0] OP_ADD    = 6'b000010;
    localparam logic [OP_W-1:0] OP_SUB    = 6'b000011;
    localparam logic [OP_W-1:0] OP_ADD3   = 6'b000100;
    localparam logic [OP_W-1:0] OP_LT     = 6'b001110;
    localparam logic [OP_W-1:0] OP_EQ     = 6'b010000;
    localparam logic [OP_W-1:0] OP_SELECT = 6'b110000;

    // Compare ops produce COMPARE for the predicate flag and never write rd.
    function automatic logic is_compare(input logic [OP_W-1:0] op);
        return (op[5:4] == 2'b01) || (op[5:1] == 5'b00111);
    endfunction

    // Ops that consume the predicate flag on SELECT.
    function automatic logic uses_select(input logic [OP_W-1:0] op);
        return op[5:3] == 3'b110;
    endfunction

endpackage

// File: rtl/fu_sync_fifo.sv
// rtl/fu_sync_fifo.sv - synchronous FIFO holding decoded instructions
// Purpose: DEPTH x WIDTH first-word-fall-through queue.
// Ports: clk, rst (sync, active-high), push/wdata, pop/rdata, full, empty.
module fu_sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);

    localparam int PW = $clog2(DEPTH);
    localparam logic [PW:0] PTR_ONE = {{PW{1'b0}}, 1'b1};

    // Pointers carry one extra wrap bit to tell full from empty.
    logic [PW:0]      wr_ptr_q, wr_ptr_d;
    logic [PW:0]      rd_ptr_q, rd_ptr_d;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];

    assign empty = (wr_ptr_q == rd_ptr_q);
    assign full  = (wr_ptr_q[PW] != rd_ptr_q[PW]) && (wr_ptr_q[PW-1:0] == rd_ptr_q[PW-1:0]);
    assign rdata = mem_q[rd_ptr_q[PW-1:0]];

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        mem_d    = mem_q;
        if (push && !full) begin
            mem_d[wr_ptr_q[PW-1:0]] = wdata;
            wr_ptr_d = wr_ptr_q + PTR_ONE;
        end
        if (pop && !empty) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

endmodule

// File: rtl/fu_issue_stage.sv
// rtl/fu_issue_stage.sv - instruction buffer, register file and issue/writeback for the functional unit
// Purpose: queue instructions, read operands with writeback bypass, issue one per cycle
//          with interlocks, and write Z / COMPARE back two edges after issue.
// Ports: CLOCK/RESET; IN_* instruction push; WR_* external RF load; DBG_* RF peek;
//        PRED flag; A/B/C/INST/SELECT to FU; Z/COMPARE from FU; BUSY.
module fu_issue_stage
    import fu_isa_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int NREGS = 8,
    parameter int AW    = 3
) (
    input  logic              CLOCK,
    input  logic              RESET,
    input  logic              IN_VALID,
    output logic              IN_READY,
    input  logic [OP_W-1:0]   IN_OP,
    input  logic [AW-1:0]     IN_RD,
    input  logic [AW-1:0]     IN_RA,
    input  logic [AW-1:0]     IN_RB,
    input  logic [AW-1:0]     IN_RC,
    input  logic              WR_EN,
    input  logic [AW-1:0]     WR_ADDR,
    input  logic [DATA_W-1:0] WR_DATA,
    input  logic [AW-1:0]     DBG_ADDR,
    output logic [DATA_W-1:0] DBG_DATA,
    output logic              PRED,
    output logic [DATA_W-1:0] A,
    output logic [DATA_W-1:0] B,
    output logic [DATA_W-1:0] C,
    output logic [OP_W-1:0]   INST,
    output logic              SELECT,
    input  logic [DATA_W-1:0] Z,
    input  logic              COMPARE,
    output logic              BUSY
);

    localparam int FW = OP_W + 4 * AW;

    logic [FW-1:0]     fifo_rdata;
    logic              fifo_full, fifo_empty, fifo_push, fifo_pop;
    logic [OP_W-1:0]   head_op;
    logic [AW-1:0]     head_rd, head_ra, head_rb, head_rc;

    logic [DATA_W-1:0] rf_q [NREGS];
    logic [DATA_W-1:0] rf_d [NREGS];
    logic              pred_q, pred_d;
    logic [DATA_W-1:0] a_q, a_d, b_q, b_d, c_q, c_d;
    logic [OP_W-1:0]   inst_q, inst_d;
    logic              sel_q, sel_d;

    // ex_*: instruction on the FU inputs this cycle; wb_*: instruction whose Z/COMPARE is valid now.
    logic              ex_valid_q, ex_valid_d, ex_cmp_q, ex_cmp_d;
    logic [AW-1:0]     ex_rd_q, ex_rd_d;
    logic              wb_valid_q, wb_valid_d, wb_cmp_q, wb_cmp_d;
    logic [AW-1:0]     wb_rd_q, wb_rd_d;

    logic              wb_write, src_hit, hazard;

    fu_sync_fifo #(.WIDTH(FW), .DEPTH(DEPTH)) u_fifo (
        .clk   (CLOCK),
        .rst   (RESET),
        .push  (fifo_push),
        .wdata ({IN_OP, IN_RD, IN_RA, IN_RB, IN_RC}),
        .pop   (fifo_pop),
        .rdata (fifo_rdata),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    assign {head_op, head_rd, head_ra, head_rb, head_rc} = fifo_rdata;

    assign wb_write = wb_valid_q && !wb_cmp_q && (wb_rd_q != '0);

    // Operand read with write-through of this edge's FU writeback; external loads are not bypassed.
    function automatic logic [DATA_W-1:0] read_fwd(input logic [AW-1:0] addr);
        if (addr == '0)
            return '0;
        if (wb_write && (wb_rd_q == addr))
            return Z;
        return rf_q[addr];
    endfunction

    assign src_hit = (head_ra == ex_rd_q) || (head_rb == ex_rd_q) || (head_rc == ex_rd_q);
    assign hazard  = ex_valid_q && ((!ex_cmp_q && (ex_rd_q != '0) && src_hit) ||
                                    (ex_cmp_q && uses_select(head_op)));

    assign IN_READY  = !fifo_full;
    assign fifo_push = IN_VALID && !fifo_full;
    assign fifo_pop  = !fifo_empty && !hazard;

    always_comb begin
        rf_d = rf_q;
        if (WR_EN && (WR_ADDR != '0))
            rf_d[WR_ADDR] = WR_DATA;
        // FU writeback is applied last so it wins an address collision.
        if (wb_write)
            rf_d[wb_rd_q] = Z;
        pred_d = (wb_valid_q && wb_cmp_q) ? COMPARE : pred_q;
    end

    always_comb begin
        a_d        = a_q;
        b_d        = b_q;
        c_d        = c_q;
        inst_d     = inst_q;
        sel_d      = sel_q;
        ex_valid_d = 1'b0;
        ex_rd_d    = ex_rd_q;
        ex_cmp_d   = ex_cmp_q;
        if (fifo_pop) begin
            a_d        = read_fwd(head_ra);
            b_d        = read_fwd(head_rb);
            c_d        = read_fwd(head_rc);
            inst_d     = head_op;
            sel_d      = pred_d;
            ex_valid_d = 1'b1;
            ex_rd_d    = head_rd;
            ex_cmp_d   = is_compare(head_op);
        end
        wb_valid_d = ex_valid_q;
        wb_rd_d    = ex_rd_q;
        wb_cmp_d   = ex_cmp_q;
    end

    always_ff @(posedge CLOCK) begin
        if (RESET) begin
            for (int i = 0; i < NREGS; i++)
                rf_q[i] <= '0;
            pred_q     <= 1'b0;
            a_q        <= '0;
            b_q        <= '0;
            c_q        <= '0;
            inst_q     <= '0;
            sel_q      <= 1'b0;
            ex_valid_q <= 1'b0;
            ex_rd_q    <= '0;
            ex_cmp_q   <= 1'b0;
            wb_valid_q <= 1'b0;
            wb_rd_q    <= '0;
            wb_cmp_q   <= 1'b0;
        end else begin
            rf_q       <= rf_d;
            pred_q     <= pred_d;
            a_q        <= a_d;
            b_q        <= b_d;
            c_q        <= c_d;
            inst_q     <= inst_d;
            sel_q      <= sel_d;
            ex_valid_q <= ex_valid_d;
            ex_rd_q    <= ex_rd_d;
            ex_cmp_q   <= ex_cmp_d;
            wb_valid_q <= wb_valid_d;
            wb_rd_q    <= wb_rd_d;
            wb_cmp_q   <= wb_cmp_d;
        end
    end

    assign A        = a_q;
    assign B        = b_q;
    assign C        = c_q;
    assign INST     = inst_q;
    assign SELECT   = sel_q;
    assign PRED     = pred_q;
    assign DBG_DATA = (DBG_ADDR == '0) ? '0 : rf_q[DBG_ADDR];
    assign BUSY     = !fifo_empty || ex_valid_q || wb_valid_q;

endmodule

// File: tb/tb_fu_issue_stage.sv
// tb/tb_fu_issue_stage.sv - self-checking bench for fu_issue_stage
module tb_fu_issue_stage;

    localparam int DEPTH = 4;

    logic        CLOCK = 1'b0;
    logic        RESET = 1'b1;
    logic        IN_VALID = 1'b0;
    logic        IN_READY;
    logic [5:0]  IN_OP = '0;
    logic [2:0]  IN_RD = '0, IN_RA = '0, IN_RB = '0, IN_RC = '0;
    logic        WR_EN = 1'b0;
    logic [2:0]  WR_ADDR = '0;
    logic [31:0] WR_DATA = '0;
    logic [2:0]  DBG_ADDR = '0;
    logic [31:0] DBG_DATA;
    logic        PRED;
    logic [31:0] A, B, C;
    logic [5:0]  INST;
    logic        SELECT;
    logic [31:0] Z = '0;
    logic        COMPARE = 1'b0;
    logic        BUSY;

    fu_issue_stage #(.DEPTH(DEPTH), .NREGS(8), .AW(3)) dut (
        .CLOCK(CLOCK), .RESET(RESET), .IN_VALID(IN_VALID), .IN_READY(IN_READY),
        .IN_OP(IN_OP), .IN_RD(IN_RD), .IN_RA(IN_RA), .IN_RB(IN_RB), .IN_RC(IN_RC),
        .WR_EN(WR_EN), .WR_ADDR(WR_ADDR), .WR_DATA(WR_DATA),
        .DBG_ADDR(DBG_ADDR), .DBG_DATA(DBG_DATA), .PRED(PRED),
        .A(A), .B(B), .C(C), .INST(INST), .SELECT(SELECT),
        .Z(Z), .COMPARE(COMPARE), .BUSY(BUSY)
    );

    always #5 CLOCK = ~CLOCK;

    localparam logic [5:0] ADD = 6'b000010, SUB = 6'b000011, LT = 6'b001110, SEL = 6'b110000;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    bit chk_en = 0;
    bit saw_not_ready = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    // Reference FU behaviour used both to drive Z/COMPARE and to predict results.
    task automatic fu_func(input logic [5:0] op, input logic [31:0] a, input logic [31:0] b,
                           input logic [31:0] c, input logic s,
                           output logic [31:0] z, output logic cmp);
        z = '0;
        cmp = 1'b0;
        case (op)
            6'b000010: z = a + b;
            6'b000011: z = a - b;
            6'b000100: z = a + b + c;
            6'b001110: cmp = (a < b);
            6'b010000: cmp = (a == b);
            6'b110000: z = s ? b : a;
            default:   z = '0;
        endcase
    endtask

    function automatic bit spec_is_compare(input logic [5:0] op);
        return (op[5:4] == 2'b01) || (op[5:1] == 5'b00111);
    endfunction

    // FU: sees operands presented during cycle n, drives Z/COMPARE during n+1.
    logic [31:0] fu_nz;
    logic        fu_ncmp;
    always @(negedge CLOCK) fu_func(INST, A, B, C, SELECT, fu_nz, fu_ncmp);
    always @(posedge CLOCK) begin
        #1;
        Z = fu_nz;
        COMPARE = fu_ncmp;
    end

    always @(posedge CLOCK) cyc++;

    // Behavioural model: instruction queue, architectural RF/pred, and a list of results
    // that land two edges after their instruction issues.
    typedef struct { logic [5:0] op; logic [2:0] rd, ra, rb, rc; } ins_t;
    typedef struct { int due; bit cmp; logic [2:0] rd; logic [31:0] val; } wb_t;

    ins_t        m_q[$];
    wb_t         m_wb[$];
    logic [31:0] m_rf[8];
    logic        m_pred;
    logic [31:0] m_a, m_b, m_c;
    logic [5:0]  m_inst;
    logic        m_sel;
    bit          p_valid, p_cmp;
    logic [2:0]  p_rd;
    int          m_edge = 0;

    bit          mt_full, fw_valid, fw_pv, fw_pred, mt_haz, mt_cmp;
    logic [2:0]  fw_rd;
    logic [31:0] fw_val, mt_z;
    ins_t        mt_h;
    wb_t         mt_w;

    function automatic logic [31:0] m_read(input logic [2:0] r);
        if (r == 3'd0) return '0;
        if (fw_valid && fw_rd == r) return fw_val;
        return m_rf[r];
    endfunction

    always @(posedge CLOCK) begin
        if (RESET) begin
            m_q.delete();
            m_wb.delete();
            for (int i = 0; i < 8; i++) m_rf[i] = '0;
            m_pred = 0; m_a = '0; m_b = '0; m_c = '0; m_inst = '0; m_sel = 0;
            p_valid = 0; p_cmp = 0; p_rd = '0;
        end else begin
            mt_full = (m_q.size() >= DEPTH);
            fw_valid = 0; fw_pv = 0; fw_pred = 0; fw_rd = '0; fw_val = '0;
            if (m_wb.size() > 0 && m_wb[0].due == m_edge) begin
                mt_w = m_wb.pop_front();
                if (mt_w.cmp) begin
                    fw_pv = 1; fw_pred = mt_w.val[0];
                end else if (mt_w.rd != 3'd0) begin
                    fw_valid = 1; fw_rd = mt_w.rd; fw_val = mt_w.val;
                end
            end
            if (m_q.size() > 0) begin
                mt_h = m_q[0];
                mt_haz = p_valid && ((!p_cmp && p_rd != 3'd0 &&
                                      (p_rd == mt_h.ra || p_rd == mt_h.rb || p_rd == mt_h.rc)) ||
                                     (p_cmp && mt_h.op[5:3] == 3'b110));
            end else begin
                mt_haz = 1;
            end
            if (!mt_haz) begin
                void'(m_q.pop_front());
                m_a = m_read(mt_h.ra);
                m_b = m_read(mt_h.rb);
                m_c = m_read(mt_h.rc);
                m_inst = mt_h.op;
                m_sel = fw_pv ? fw_pred : m_pred;
                fu_func(mt_h.op, m_a, m_b, m_c, m_sel, mt_z, mt_cmp);
                mt_w.due = m_edge + 2;
                mt_w.cmp = spec_is_compare(mt_h.op);
                mt_w.rd = mt_h.rd;
                mt_w.val = mt_w.cmp ? {31'd0, mt_cmp} : mt_z;
                m_wb.push_back(mt_w);
                p_valid = 1; p_rd = mt_h.rd; p_cmp = mt_w.cmp;
            end else begin
                p_valid = 0;
            end
            if (WR_EN && WR_ADDR != 3'd0) m_rf[WR_ADDR] = WR_DATA;
            if (fw_valid) m_rf[fw_rd] = fw_val;
            if (fw_pv) m_pred = fw_pred;
            if (IN_VALID && !mt_full) begin
                mt_h.op = IN_OP; mt_h.rd = IN_RD; mt_h.ra = IN_RA; mt_h.rb = IN_RB; mt_h.rc = IN_RC;
                m_q.push_back(mt_h);
            end
        end
        m_edge++;
    end

    always @(negedge CLOCK) begin
        if (chk_en) begin
            if (!IN_READY) saw_not_ready = 1;
            check("in_ready", IN_READY, (m_q.size() < DEPTH));
            check("busy", BUSY, (m_q.size() > 0 || m_wb.size() > 0));
            check("a", A, m_a);
            check("b", B, m_b);
            check("c", C, m_c);
            check("inst", INST, m_inst);
            check("select", SELECT, m_sel);
            check("pred", PRED, m_pred);
            check("dbg_data", DBG_DATA, m_rf[DBG_ADDR]);
        end
    end

    task automatic tick();
        @(negedge CLOCK);
        #1;
    endtask

    task automatic do_reset();
        RESET = 1; IN_VALID = 0; WR_EN = 0;
        tick(); tick();
        RESET = 0;
    endtask

    task automatic wr(input logic [2:0] addr, input logic [31:0] data);
        WR_EN = 1; WR_ADDR = addr; WR_DATA = data;
        tick();
        WR_EN = 0;
    endtask

    task automatic push(input logic [5:0] op, input logic [2:0] rd, input logic [2:0] ra,
                        input logic [2:0] rb, input logic [2:0] rc);
        bit rdy;
        int n;
        IN_VALID = 1; IN_OP = op; IN_RD = rd; IN_RA = ra; IN_RB = rb; IN_RC = rc;
        n = 0;
        do begin
            rdy = IN_READY;
            tick();
            n++;
        end while (!rdy && n < 30);
        check("push_accept", rdy, 1);
        IN_VALID = 0;
    endtask

    task automatic wait_inst(input logic [5:0] op, output int t);
        int n;
        n = 0;
        while (INST !== op && n < 10) begin
            tick();
            n++;
        end
        check("issue_seen", INST, op);
        t = cyc;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic peek(input string name, input logic [2:0] r, input logic [31:0] exp);
        DBG_ADDR = r;
        #1;
        check(name, DBG_DATA, exp);
    endtask

    int t0, t1;

    initial begin
        do_reset();
        chk_en = 1;
        check("rst_in_ready", IN_READY, 1);
        check("rst_busy", BUSY, 0);
        check("rst_a", A, 0);
        check("rst_inst", INST, 0);
        check("rst_pred", PRED, 0);

        // Basic ADD r3 = r1 + r2
        wr(1, 5); wr(2, 7);
        push(ADD, 3, 1, 2, 0);
        wait_inst(ADD, t0);
        check("add_a", A, 32'd5);
        check("add_b", B, 32'd7);
        DBG_ADDR = 3;
        tick();
        check("r3_before_wb", DBG_DATA, 32'd0);
        tick();
        check("r3_after_wb", DBG_DATA, 32'h0000000C);

        // Dependent pair issues 2 cycles apart with bypass
        do_reset();
        wr(1, 5); wr(2, 7);
        push(ADD, 3, 1, 2, 0);
        push(SUB, 4, 3, 1, 0);
        wait_inst(ADD, t0);
        wait_inst(SUB, t1);
        check("dep_spacing", t1 - t0, 2);
        check("sub_a_bypass", A, 32'd12);
        idle(3);
        peek("r4", 4, 32'd7);

        // Compare then SELECT: one stall, predicate bypass
        do_reset();
        wr(1, 5); wr(2, 7); wr(6, 33);
        push(LT, 6, 1, 2, 0);
        push(SEL, 5, 1, 2, 0);
        wait_inst(LT, t0);
        wait_inst(SEL, t1);
        check("sel_spacing", t1 - t0, 2);
        check("select_bit", SELECT, 1);
        idle(3);
        check("pred_set", PRED, 1);
        peek("r5", 5, 32'd7);
        peek("r6_untouched", 6, 32'd33);

        // Fill FIFO with a dependency chain rotating through ra, rb, rc
        do_reset();
        saw_not_ready = 0;
        wr(1, 5); wr(2, 7);
        push(ADD, 3, 1, 2, 0);
        for (int k = 1; k < 9; k++) begin
            case (k % 3)
                1: push(ADD, 3, 3, 1, 0);
                2: push(ADD, 3, 1, 3, 0);
                default: push(ADD, 3, 1, 2, 3);
            endcase
        end
        idle(12);
        check("in_ready_low_seen", saw_not_ready, 1);
        peek("r3_chain", 3, 32'd22);

        // Writeback vs external write on the same edge
        do_reset();
        wr(1, 5); wr(2, 7);
        push(ADD, 3, 1, 2, 0);
        wait_inst(ADD, t0);
        tick();
        WR_EN = 1; WR_ADDR = 3; WR_DATA = 99;
        tick();
        WR_EN = 0;
        peek("r3_wb_wins", 3, 32'd12);
        push(SUB, 3, 2, 1, 0);
        wait_inst(SUB, t0);
        tick();
        WR_EN = 1; WR_ADDR = 6; WR_DATA = 99;
        tick();
        WR_EN = 0;
        peek("r3_both", 3, 32'd2);
        peek("r6_both", 6, 32'd99);

        // r0 discards writes
        push(ADD, 0, 1, 2, 0);
        idle(4);
        peek("r0_zero", 0, 32'd0);

        // Reset with 3 queued and 1 in flight
        push(ADD, 7, 1, 2, 0);
        for (int k = 0; k < 4; k++) push(ADD, 7, 7, 1, 0);
        check("busy_before_rst", BUSY, 1);
        RESET = 1;
        tick();
        check("busy_after_rst", BUSY, 0);
        check("ready_after_rst", IN_READY, 1);
        RESET = 0;
        idle(3);
        peek("r7_after_rst", 7, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog got timeout expected finish");
        $fatal(1);
    end

endmodule
